// File: rtl/wm_cycle_timer.sv
// Wash/spin phase timer and watchdog: timeouts rise D*TICK_DIV edges after phase entry, pause stretches by one clock each.
// Outputs are registered; a controller that does not leave a phase within ACK_LIMIT clocks of its timeout latches a sticky fault.
module wm_cycle_timer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TICK_DIV    = 1,
  parameter int unsigned WASH_QUICK  = 100,
  parameter int unsigned WASH_NORMAL = 200,
  parameter int unsigned WASH_HEAVY  = 400,
  parameter int unsigned SPIN_SHORT  = 50,
  parameter int unsigned SPIN_LONG   = 120,
  parameter int unsigned ACK_LIMIT   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             motor_on,
  input  logic             drain_value_on,
  input  logic [1:0]       program_sel,
  input  logic             pause,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic [CNT_W-1:0] time_left,
  output logic [1:0]       phase,
  output logic             fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_WASH_RUN, S_WASH_DONE, S_SPIN_RUN, S_SPIN_DONE, S_FAULT
  } state_t;

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_LIMIT - 1);

  // Zero-length phases still last one tick; oversized ones wrap to the counter width.
  function automatic logic [CNT_W-1:0] dur_of(input int unsigned d);
    logic [CNT_W-1:0] t;
    t = CNT_W'(d);
    return (t == '0) ? CNT_W'(1) : t;
  endfunction

  localparam logic [CNT_W-1:0] D_WQ = dur_of(WASH_QUICK);
  localparam logic [CNT_W-1:0] D_WN = dur_of(WASH_NORMAL);
  localparam logic [CNT_W-1:0] D_WH = dur_of(WASH_HEAVY);
  localparam logic [CNT_W-1:0] D_SS = dur_of(SPIN_SHORT);
  localparam logic [CNT_W-1:0] D_SL = dur_of(SPIN_LONG);

  state_t           state;
  logic [1:0]       prog_q;
  logic [PRE_W-1:0] presc;
  logic [CNT_W-1:0] cnt;
  logic             wash_act;
  logic             spin_act;
  logic             cur_act;
  logic [CNT_W-1:0] wash_dur;
  logic [CNT_W-1:0] spin_dur;

  assign wash_act = motor_on & ~drain_value_on;
  assign spin_act = motor_on & drain_value_on;
  assign cur_act  = ((state == S_WASH_RUN) || (state == S_WASH_DONE)) ? wash_act : spin_act;

  always_comb begin
    wash_dur = D_WN;
    case (program_sel)
      2'b00:   wash_dur = D_WQ;
      2'b10:   wash_dur = D_WH;
      default: wash_dur = D_WN;
    endcase
    spin_dur = (prog_q == 2'b00) ? D_SS : D_SL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      prog_q        <= 2'b01;
      presc         <= '0;
      cnt           <= '0;
      cycle_timeout <= 1'b0;
      spin_timeout  <= 1'b0;
      time_left     <= '0;
      phase         <= 2'b00;
      fault         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wash_act) begin
            state     <= S_WASH_RUN;
            prog_q    <= program_sel;
            cnt       <= wash_dur;
            time_left <= wash_dur;
            presc     <= '0;
            phase     <= 2'b01;
          end else if (spin_act) begin
            state     <= S_SPIN_RUN;
            cnt       <= spin_dur;
            time_left <= spin_dur;
            presc     <= '0;
            phase     <= 2'b10;
          end
        end

        S_WASH_RUN, S_SPIN_RUN: begin
          if (!cur_act) begin
            state     <= S_IDLE;
            cnt       <= '0;
            time_left <= '0;
            presc     <= '0;
            phase     <= 2'b00;
          end else if (!pause) begin
            if (presc == PRE_LAST) begin
              presc <= '0;
              if (cnt == CNT_W'(1)) begin
                // Counter is recycled as the acknowledge watchdog from here on.
                cnt       <= '0;
                time_left <= '0;
                if (state == S_WASH_RUN) begin
                  state         <= S_WASH_DONE;
                  cycle_timeout <= 1'b1;
                end else begin
                  state        <= S_SPIN_DONE;
                  spin_timeout <= 1'b1;
                end
              end else begin
                cnt       <= cnt - CNT_W'(1);
                time_left <= cnt - CNT_W'(1);
              end
            end else begin
              presc <= presc + PRE_W'(1);
            end
          end
        end

        S_WASH_DONE, S_SPIN_DONE: begin
          if (!cur_act) begin
            state         <= S_IDLE;
            cnt           <= '0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            phase         <= 2'b00;
          end else if (cnt == ACK_LAST) begin
            state         <= S_FAULT;
            cnt           <= '0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            phase         <= 2'b11;
            fault         <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_FAULT: begin
          state <= S_FAULT;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
